// File: rtl/dm_cache_wt.sv
// Direct-mapped, write-through, word-addressed cache with valid/ready requester
// handshake, variable-latency memory handshake and saturating hit/miss counters.
module dm_cache_wt #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int INDEX_W = 2,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic              flush,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_hit,
   output logic              mem_req,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [CNT_W-1:0]  miss_cnt
);

   localparam int LINES = 2 ** INDEX_W;
   localparam int TAG_W = ADDR_W - INDEX_W;

   typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

   state_t              state_reg, state_next;
   logic [DATA_W-1:0]   data_mem [LINES];
   logic [TAG_W-1:0]    tag_mem  [LINES];
   logic [LINES-1:0]    valid_reg;

   logic [ADDR_W-1:0]   addr_reg;
   logic                wr_reg;
   logic [DATA_W-1:0]   wdata_reg;
   logic                hit_reg;
   logic [DATA_W-1:0]   rdata_reg;
   logic                rsp_hit_reg;
   logic [CNT_W-1:0]    hit_cnt_reg, miss_cnt_reg;

   logic [INDEX_W-1:0]  req_idx;
   logic [TAG_W-1:0]    req_tag;
   logic                lookup_hit;
   logic                accept;
   logic                flush_now;
   logic                line_we;
   logic                line_set_valid;
   logic [INDEX_W-1:0]  line_idx;
   logic [TAG_W-1:0]    line_tag;
   logic [DATA_W-1:0]   line_data;

   assign req_idx    = req_addr[INDEX_W-1:0];
   assign req_tag    = req_addr[ADDR_W-1:INDEX_W];
   assign lookup_hit = valid_reg[req_idx] && (tag_mem[req_idx] == req_tag);
   assign flush_now  = (state_reg == IDLE) && flush;

   always_comb begin
      state_next     = state_reg;
      req_ready      = 1'b0;
      accept         = 1'b0;
      line_we        = 1'b0;
      line_set_valid = 1'b0;
      line_idx       = req_idx;
      line_tag       = req_tag;
      line_data      = req_wdata;
      case (state_reg)
         IDLE: begin
            req_ready = ~flush;
            accept    = req_valid && ~flush;
            if (accept) begin
               state_next = (!req_wr && lookup_hit) ? RESP : MEM;
               // Write hit keeps the line coherent with the write-through data
               line_we    = req_wr && lookup_hit;
            end
         end
         MEM: begin
            if (mem_ack) begin
               state_next = RESP;
               if (!wr_reg) begin
                  line_we        = 1'b1;
                  line_set_valid = 1'b1;
                  line_idx       = addr_reg[INDEX_W-1:0];
                  line_tag       = addr_reg[ADDR_W-1:INDEX_W];
                  line_data      = mem_rdata;
               end
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (line_we) begin
         data_mem[line_idx] <= line_data;
         tag_mem[line_idx]  <= line_tag;
      end
   end

   generate
      for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               valid_reg[gi] <= 1'b0;
            else if (flush_now)
               valid_reg[gi] <= 1'b0;
            else if (line_set_valid && (line_idx == INDEX_W'(gi)))
               valid_reg[gi] <= 1'b1;
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         addr_reg     <= '0;
         wr_reg       <= 1'b0;
         wdata_reg    <= '0;
         hit_reg      <= 1'b0;
         rdata_reg    <= '0;
         rsp_hit_reg  <= 1'b0;
         hit_cnt_reg  <= '0;
         miss_cnt_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            addr_reg  <= req_addr;
            wr_reg    <= req_wr;
            wdata_reg <= req_wdata;
            hit_reg   <= lookup_hit;
            if (!req_wr && lookup_hit) begin
               rdata_reg   <= data_mem[req_idx];
               rsp_hit_reg <= 1'b1;
            end
            if (lookup_hit) begin
               if (hit_cnt_reg != '1) hit_cnt_reg <= hit_cnt_reg + CNT_W'(1);
            end else begin
               if (miss_cnt_reg != '1) miss_cnt_reg <= miss_cnt_reg + CNT_W'(1);
            end
         end
         if (state_reg == MEM && mem_ack) begin
            rsp_hit_reg <= wr_reg ? hit_reg : 1'b0;
            if (!wr_reg) rdata_reg <= mem_rdata;
         end
      end
   end

   assign rsp_valid = (state_reg == RESP);
   assign rsp_rdata = rdata_reg;
   assign rsp_hit   = rsp_hit_reg;
   assign mem_req   = (state_reg == MEM);
   assign mem_wr    = wr_reg;
   assign mem_addr  = addr_reg;
   assign mem_wdata = wdata_reg;
   assign hit_cnt   = hit_cnt_reg;
   assign miss_cnt  = miss_cnt_reg;

endmodule
